// File: rtl/clock_step_controller_pkg.sv
// Shared encodings and helpers for the CPU clock step controller.
// Mode and state encodings plus the budget reload rule live here so the top stays small.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_FREE  = 2'b00,
        MODE_STEP  = 2'b01,
        MODE_BURST = 2'b10
    } mode_t;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STOPPED = 1'b1
    } state_t;

    localparam int BUDGET_W = 16;

    // Index of the budget-exhausted bit inside stop_cause.
    function automatic int budget_bit(input int num_stop);
        return num_stop;
    endfunction

    // The unused encoding 2'b11 behaves as free-run.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        mode_t m;
        case (raw)
            2'b01:   m = MODE_STEP;
            2'b10:   m = MODE_BURST;
            default: m = MODE_FREE;
        endcase
        return m;
    endfunction

    function automatic logic [BUDGET_W-1:0] budget_load(input mode_t m,
                                                        input logic [BUDGET_W-1:0] blen);
        logic [BUDGET_W-1:0] b;
        case (m)
            MODE_STEP:  b = BUDGET_W'(1);
            MODE_BURST: b = (blen == '0) ? BUDGET_W'(1) : blen;
            default:    b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/clock_step_controller_prescaler.sv
// Prescaler for the CPU clock: counts while enabled and ticks when the count matches div_sel.
// Up-counter with equality compare, so a div_sel below the current count wraps through 2^DIV_WIDTH.
module clk_prescaler #(
    parameter int DIV_WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic [DIV_WIDTH-1:0] i_div_sel,
    output logic                 o_tick
);

    logic [DIV_WIDTH-1:0] r_count;
    logic                 w_tick;

    assign w_tick = i_en && (r_count == i_div_sel);
    assign o_tick = w_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr || w_tick) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/debouncer.sv
// Team debouncer: synchronises a raw input and emits a one-clk pulse on a debounced falling edge.
// An input change is accepted only after it has differed from the stable level for 2^N clk.
module debouncer #(
    parameter int   N    = 16,
    parameter logic INIT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_fall
);

    logic [1:0]   r_sync;
    logic         r_stable;
    logic [N-1:0] r_cnt;
    logic         r_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= {2{INIT}};
            r_stable <= INIT;
            r_cnt    <= '0;
            r_fall   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_fall <= 1'b0;
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (&r_cnt) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
                r_fall   <= r_stable & ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_fall = r_fall;

endmodule

// File: rtl/clock_step_controller.sv
// CPU clock generator: divided cpu_clk with stop gating, step/burst budgets and debounced resume.
// State table:  ST_RUN | prescaler counting, cpu_clk toggles on tick  ;  ST_STOPPED | cpu_clk held, waiting for resume pulse
module clock_step_controller
    import clock_ctrl_pkg::*;
#(
    parameter int                  DIV_WIDTH     = 18,
    parameter int                  NUM_STOP      = 5,
    parameter logic [NUM_STOP-1:0] AUX_MASK      = {NUM_STOP{1'b0}},
    parameter int                  GRACE_TOGGLES = 2,
    parameter int                  DEB_WIDTH     = 16,
    parameter int                  AUX_DEB_WIDTH = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] div_sel,
    input  logic [1:0]           mode,
    input  logic [15:0]          burst_len,
    input  logic [NUM_STOP-1:0]  stop_req,
    input  logic                 resume_confirm,
    input  logic                 resume_aux,
    output logic                 cpu_clk,
    output logic                 stopped,
    output logic [NUM_STOP:0]    stop_cause,
    output logic [31:0]          cycle_count
);

    localparam int BB = budget_bit(NUM_STOP);
    localparam int GW = (GRACE_TOGGLES < 2) ? 1 : $clog2(GRACE_TOGGLES + 1);
    localparam logic [GW-1:0] GRACE_INIT = GW'(GRACE_TOGGLES);

    state_t              r_state;
    mode_t               r_mode_q;
    logic [BUDGET_W-1:0] r_budget;
    logic [GW-1:0]       r_grace;
    logic                r_cpu_clk;
    logic                r_stopped;
    logic [NUM_STOP:0]   r_cause;
    logic [31:0]         r_count;

    logic w_tick;
    logic w_conf_fall;
    logic w_aux_fall;
    logic w_ext;
    logic w_bud;
    logic w_aux_sel;
    logic w_resume;

    clk_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (reset),
        .i_en     (r_state == ST_RUN),
        .i_clr    (r_state == ST_STOPPED),
        .i_div_sel(div_sel),
        .o_tick   (w_tick)
    );

    debouncer #(
        .N   (DEB_WIDTH),
        .INIT(1'b1)
    ) u_deb_confirm (
        .clk   (clk),
        .rst_n (reset),
        .i_raw (resume_confirm),
        .o_fall(w_conf_fall)
    );

    debouncer #(
        .N   (AUX_DEB_WIDTH),
        .INIT(1'b0)
    ) u_deb_aux (
        .clk   (clk),
        .rst_n (reset),
        .i_raw (resume_aux),
        .o_fall(w_aux_fall)
    );

    assign w_ext     = (|stop_req) && (r_grace == '0);
    assign w_bud     = (r_mode_q != MODE_FREE) && (r_budget == '0) && !r_cpu_clk;
    // Any latched cause routed to the peripheral path makes the push button ineffective.
    assign w_aux_sel = |(r_cause[NUM_STOP-1:0] & AUX_MASK);
    assign w_resume  = w_aux_sel ? w_aux_fall : w_conf_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_cpu_clk <= 1'b0;
            r_stopped <= 1'b0;
            r_cause   <= '0;
            r_count   <= '0;
            r_grace   <= GRACE_INIT;
            r_mode_q  <= decode_mode(mode);
            r_budget  <= budget_load(decode_mode(mode), burst_len);
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_tick) begin
                        if (w_ext || w_bud) begin
                            r_state            <= ST_STOPPED;
                            r_stopped          <= 1'b1;
                            r_cause[BB]        <= w_bud;
                            r_cause[BB-1:0]    <= stop_req & {NUM_STOP{w_ext}};
                        end else begin
                            r_cpu_clk <= ~r_cpu_clk;
                            if (r_grace != '0) begin
                                r_grace <= r_grace - 1'b1;
                            end
                            if (r_cpu_clk) begin
                                r_count <= r_count + 32'd1;
                                if ((r_mode_q != MODE_FREE) && (r_budget != '0)) begin
                                    r_budget <= r_budget - 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_STOPPED: begin
                    if (w_resume) begin
                        r_state   <= ST_RUN;
                        r_stopped <= 1'b0;
                        r_cause   <= '0;
                        r_grace   <= GRACE_INIT;
                        r_mode_q  <= decode_mode(mode);
                        r_budget  <= budget_load(decode_mode(mode), burst_len);
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign cpu_clk     = r_cpu_clk;
    assign stopped     = r_stopped;
    assign stop_cause  = r_cause;
    assign cycle_count = r_count;

endmodule

// File: doc/clock_step_controller.md
Name: clock_step_controller

Overview:
- Next-generation CPU clock generator for the unicycle MIPS system.
- Divides the board clock into the processor clock `cpu_clk` using a runtime-programmable divider.
- Gates `cpu_clk` on any of NUM_STOP stop requests. Resumes on a debounced push (`resume_confirm`) or a debounced peripheral-done pulse (`resume_aux`), selected per source by mask.
- Adds free-run, single-step and burst modes, a latched stop cause, and a retired-cycle counter for the debug display.

Parameters:
- DIV_WIDTH, 18: width of the prescaler and of `div_sel`.
- NUM_STOP, 5: number of level stop-request inputs.
- AUX_MASK, {NUM_STOP{1'b0}}: bit i=1 means stop source i resumes on `resume_aux`; otherwise on `resume_confirm`.
- GRACE_TOGGLES, 2: `cpu_clk` toggles after a resume or reset during which external stops are ignored.
- DEB_WIDTH, 16: debouncer counter width for `resume_confirm`.
- AUX_DEB_WIDTH, 14: debouncer counter width for `resume_aux`.

Ports:
- clk  in  1  board clock; the only clock domain.
- reset  in  1  asynchronous, active-low reset.
- div_sel  in  DIV_WIDTH  prescaler terminal count; a tick occurs every div_sel+1 clk cycles.
- mode  in  2  00 free-run, 01 single-step, 10 burst, 11 treated as 00.
- burst_len  in  16  cycles per resume in burst mode; 0 is treated as 1.
- stop_req  in  NUM_STOP  level stop requests (halt, hold switch, I/O flags, interrupt, ...).
- resume_confirm  in  1  raw push button, active-low press.
- resume_aux  in  1  raw peripheral done (e.g. LCD).
- cpu_clk  out  1  divided processor clock.
- stopped  out  1  high while clock is held.
- stop_cause  out  NUM_STOP+1  latched cause; bit NUM_STOP = step/burst budget exhausted.
- cycle_count  out  32  completed `cpu_clk` cycles.

Behaviour:
- Reset (async, low):
  - `cpu_clk`=0, `stopped`=0, `stop_cause`=0, `cycle_count`=0.
  - Prescaler=0, state=RUN, grace=GRACE_TOGGLES.
  - `mode` is sampled into `mode_q` at reset; budget loaded (step: 1, burst: max(burst_len,1)).
- Prescaler:
  - Counts in RUN only; `tick` when count==div_sel, then count returns to 0.
  - `div_sel` changes take effect at the next compare. A change to a value below the current count wraps at 2^DIV_WIDTH; this is allowed and is not a hazard.
- States:
  - RUN: on `tick`, evaluate in order:
    1. ext = stop_req!=0 && grace==0.
    2. bud = mode_q!=free && budget==0 && cpu_clk==0.
    3. If ext or bud: go to STOPPED with no toggle. `stop_cause` gets stop_req (if ext) in bits [NUM_STOP-1:0], and bit NUM_STOP = bud. Both may be set. Prescaler cleared.
    4. Else toggle `cpu_clk`.
       - If grace>0, decrement grace.
       - On a 1->0 toggle: increment `cycle_count` (wraps at 2^32) and, if mode_q!=free, decrement budget (saturates at 0).
  - STOPPED: `stopped`=1, `cpu_clk` held at its current level.
    - If `stop_cause` has any bit in AUX_MASK set, only a debounced `resume_aux` falling edge resumes. Otherwise only a `resume_confirm` falling edge resumes.
    - Resume takes effect on the clk after the edge pulse: state=RUN, `stopped`=0, `stop_cause`=0, grace=GRACE_TOGGLES, `mode_q` re-sampled, budget reloaded, prescaler=0.
- Edge handling:
  - Resume edges seen in RUN are discarded.
  - A stop level still present after grace expires re-stops at the next tick.
  - `stop_req` changes during STOPPED do not alter `stop_cause`.
  - Latency: stop assertion to `stopped`=1 is at most div_sel+1 clk after the first grace-free tick. Resume edge pulse to first `cpu_clk` toggle is div_sel+2 clk.
- Debouncing:
  - Each raw resume input passes through a Debouncer (N=DEB_WIDTH / AUX_DEB_WIDTH).
  - Each Debouncer gives a one-clk falling-edge pulse after the input has been stable for 2^N clk.

Decomposition:
- Shared package (clock_ctrl_pkg):
  - mode encodings MODE_FREE/MODE_STEP/MODE_BURST.
  - state encodings ST_RUN/ST_STOPPED.
  - constant BUDGET_BIT=NUM_STOP as a function of the parameter.
- Sub-modules:
  - One natural sub-module: clk_prescaler (counter plus tick).
  - Reuse the team Debouncer twice; no new debouncer.

Test Plan:
1. reset low 3 clk, mode=00, div_sel=3, stop_req=0 -> `cpu_clk` toggles every 4 clk (period 8); `cycle_count`=3 after 24 clk from reset release; `stopped`=0.
2. Free-run, grace expired, stop_req[0]=1 -> at next tick `stopped`=1, `stop_cause`=6'b000001, `cpu_clk` frozen. Press/release `resume_confirm` (DEB_WIDTH=2) -> resumes; stop_req still 1 -> exactly 2 toggles, then stops again.
3. AUX_MASK=5'b00100, stop_req[2] -> pulsing `resume_confirm` does nothing; `resume_aux` falling edge resumes; `stop_cause` clears to 0.
4. mode=01 -> each confirm gives exactly one full `cpu_clk` cycle (0->1->0); `cycle_count` +1 per press; `stop_cause`[5]=1 each stop.
5. mode=10, burst_len=4 -> 4 cycles per resume; burst_len=0 -> 1 cycle. stop_req[1] asserted at the same tick as budget expiry -> `stop_cause`=6'b100010.
6. reset asserted mid-STOPPED and mid-prescaler count -> all outputs return to reset values immediately (async); run restarts cleanly after release.
